// File: rtl/spi_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_encoder_if
// Brief    : Byte handshake and SPI pin bundle for the SPI mode-0 master.
// Revision : 1.0
// ============================================================================
interface spi_encoder_if;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       spi_cs;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_miso;

    modport master (
        output tx_data, tx_last, tx_valid, spi_miso,
        input  tx_ready, rx_data, rx_valid, busy, spi_cs, spi_sck, spi_mosi
    );

    modport slave (
        input  tx_data, tx_last, tx_valid, spi_miso,
        output tx_ready, rx_data, rx_valid, busy, spi_cs, spi_sck, spi_mosi
    );
endinterface
`default_nettype wire

// File: rtl/spi_encoder.sv
`default_nettype none
// ============================================================================
// Module   : spi_encoder
// Brief    : SPI mode-0 master, MSB first, full duplex, SCK = clk/(2*DIV).
// Revision : 1.0
// ============================================================================
module spi_encoder #(
    parameter int DIV = 4
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    spi_encoder_if.slave bus
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_SHIFT = 3'd1;
    localparam logic [2:0] c_WAIT  = 3'd2;
    localparam logic [2:0] c_HOLD  = 3'd3;
    localparam logic [2:0] c_GAP   = 3'd4;

    localparam logic [7:0] c_HALF_MAX = 8'(DIV - 1);

    logic [2:0] r_state;
    logic [7:0] r_cnt;
    logic [2:0] r_bit;
    logic [6:0] r_tx_sh;
    logic       r_last;
    logic [7:0] r_rx_sh;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_tx_ready;
    logic       r_busy;
    logic       r_cs;
    logic       r_sck;
    logic       r_mosi;

    logic w_half_done;
    logic w_load;

    assign w_half_done = (r_cnt == c_HALF_MAX);
    // tx_ready is only ever high in IDLE or WAIT, so it alone qualifies a load
    assign w_load      = bus.tx_valid && r_tx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_cnt      <= 8'd0;
            r_bit      <= 3'd0;
            r_tx_sh    <= 7'd0;
            r_last     <= 1'b0;
            r_rx_sh    <= 8'd0;
            r_rx_data  <= 8'd0;
            r_rx_valid <= 1'b0;
            r_tx_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_cs       <= 1'b1;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_load) begin
                r_state    <= c_SHIFT;
                r_cnt      <= 8'd0;
                r_bit      <= 3'd0;
                r_tx_sh    <= bus.tx_data[6:0];
                r_last     <= bus.tx_last;
                r_tx_ready <= 1'b0;
                r_busy     <= 1'b1;
                r_cs       <= 1'b0;
                r_sck      <= 1'b0;
                r_mosi     <= bus.tx_data[7];
            end else begin
                case (r_state)
                    c_IDLE: begin
                        r_tx_ready <= 1'b1;
                    end
                    c_SHIFT: begin
                        if (w_half_done) begin
                            r_cnt <= 8'd0;
                            if (!r_sck) begin
                                r_sck   <= 1'b1;
                                r_rx_sh <= {r_rx_sh[6:0], bus.spi_miso};
                            end else begin
                                r_sck <= 1'b0;
                                // Final fall: MOSI keeps bit0, byte is delivered
                                if (r_bit == 3'd7) begin
                                    r_rx_data  <= r_rx_sh;
                                    r_rx_valid <= 1'b1;
                                    if (r_last) begin
                                        r_state <= c_HOLD;
                                    end else begin
                                        r_state    <= c_WAIT;
                                        r_tx_ready <= 1'b1;
                                    end
                                end else begin
                                    r_bit   <= r_bit + 3'd1;
                                    r_mosi  <= r_tx_sh[6];
                                    r_tx_sh <= {r_tx_sh[5:0], 1'b0};
                                end
                            end
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    c_WAIT: begin
                        r_tx_ready <= 1'b1;
                    end
                    c_HOLD: begin
                        if (w_half_done) begin
                            r_cnt   <= 8'd0;
                            r_cs    <= 1'b1;
                            r_state <= c_GAP;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    c_GAP: begin
                        if (w_half_done) begin
                            r_cnt      <= 8'd0;
                            r_state    <= c_IDLE;
                            r_tx_ready <= 1'b1;
                            r_busy     <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    default: begin
                        r_state    <= c_IDLE;
                        r_cnt      <= 8'd0;
                        r_cs       <= 1'b1;
                        r_sck      <= 1'b0;
                        r_busy     <= 1'b0;
                        r_tx_ready <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.tx_ready = r_tx_ready;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign bus.busy     = r_busy;
    assign bus.spi_cs   = r_cs;
    assign bus.spi_sck  = r_sck;
    assign bus.spi_mosi = r_mosi;

endmodule
`default_nettype wire

// File: tb/tb_spi_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_encoder
// Brief    : Directed bench for spi_encoder at DIV=1/2/3 with byte scoreboards.
// Revision : 1.0
// ============================================================================
module tb_spi_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_valid;
    logic [1:0] sel;
    logic [1:0] mode;
    logic [15:0] pat;
    int         pat_base;
    int         pat_idx;
    logic       w_miso;

    always #5 clk = ~clk;

    spi_encoder_if if1 ();
    spi_encoder_if if2 ();
    spi_encoder_if if3 ();

    spi_encoder #(.DIV(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    spi_encoder #(.DIV(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    spi_encoder #(.DIV(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    assign if1.tx_data  = tx_data;
    assign if2.tx_data  = tx_data;
    assign if3.tx_data  = tx_data;
    assign if1.tx_last  = tx_last;
    assign if2.tx_last  = tx_last;
    assign if3.tx_last  = tx_last;
    assign if1.tx_valid = tx_valid && (sel == 2'd1);
    assign if2.tx_valid = tx_valid && (sel == 2'd2);
    assign if3.tx_valid = tx_valid && (sel == 2'd3);
    assign if1.spi_miso = w_miso;
    assign if2.spi_miso = w_miso;
    assign if3.spi_miso = w_miso;

    // Outputs of the instance currently under test
    logic       m_cs, m_sck, m_mosi, m_ready, m_rxv, m_busy;
    logic [7:0] m_rxd;
    always_comb begin
        m_cs = if2.spi_cs; m_sck = if2.spi_sck; m_mosi = if2.spi_mosi;
        m_ready = if2.tx_ready; m_rxv = if2.rx_valid; m_busy = if2.busy; m_rxd = if2.rx_data;
        if (sel == 2'd1) begin
            m_cs = if1.spi_cs; m_sck = if1.spi_sck; m_mosi = if1.spi_mosi;
            m_ready = if1.tx_ready; m_rxv = if1.rx_valid; m_busy = if1.busy; m_rxd = if1.rx_data;
        end else if (sel == 2'd3) begin
            m_cs = if3.spi_cs; m_sck = if3.spi_sck; m_mosi = if3.spi_mosi;
            m_ready = if3.tx_ready; m_rxv = if3.rx_valid; m_busy = if3.busy; m_rxd = if3.rx_data;
        end
    end

    // Monitor: records MOSI bytes, received bytes and protocol anomalies
    logic       prev_sck, prev_rxv;
    int         bitn;
    logic [7:0] shreg;
    logic [7:0] obs_tx [64];
    logic [7:0] obs_rx [64];
    int n_tx_obs = 0, n_rx_obs = 0, rise_cnt = 0, rxv_cnt = 0, dbl_rxv = 0, sck_bad = 0;

    always_comb begin
        pat_idx = rise_cnt - pat_base;
        w_miso  = 1'b0;
        if (mode == 2'd1) w_miso = m_mosi;
        else if (mode == 2'd2 && pat_idx >= 0 && pat_idx < 16) w_miso = pat[15 - pat_idx];
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_sck <= 1'b0;
            prev_rxv <= 1'b0;
            bitn     <= 0;
        end else begin
            prev_sck <= m_sck;
            prev_rxv <= m_rxv;
            if (m_cs) bitn <= 0;
            if (m_cs && m_sck) sck_bad <= sck_bad + 1;
            if (m_sck && !prev_sck) begin
                rise_cnt <= rise_cnt + 1;
                shreg    <= {shreg[6:0], m_mosi};
                if (bitn == 7) begin
                    obs_tx[n_tx_obs % 64] <= {shreg[6:0], m_mosi};
                    n_tx_obs <= n_tx_obs + 1;
                    bitn     <= 0;
                end else begin
                    bitn <= bitn + 1;
                end
            end
            if (m_rxv) begin
                obs_rx[n_rx_obs % 64] <= m_rxd;
                n_rx_obs <= n_rx_obs + 1;
                rxv_cnt  <= rxv_cnt + 1;
                if (prev_rxv) dbl_rxv <= dbl_rxv + 1;
            end
        end
    end

    int tests = 0, fails = 0;
    int rd_tx = 0, rd_rx = 0;
    logic [8:0] exp_tx [$];
    logic [8:0] exp_rx [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the accept edge follows, returns at the T+1 negedge
    task automatic send(input logic [7:0] d, input bit last, input logic [7:0] rx_exp,
                        input bit push, input bit keep);
        int n;
        n = 0;
        tx_data  = d;
        tx_last  = last;
        tx_valid = 1'b1;
        if (push) begin
            exp_tx.push_back({1'b0, d});
            exp_rx.push_back({1'b0, rx_exp});
        end
        while (!m_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_accept", 32'(m_ready), 32'd1);
        @(negedge clk);
        if (!keep) tx_valid = 1'b0;
        check("cs_T1", 32'(m_cs), 32'd0);
        check("mosi_T1", 32'(m_mosi), 32'(d[7]));
        check("sck_T1", 32'(m_sck), 32'd0);
        check("ready_T1", 32'(m_ready), 32'd0);
        check("busy_T1", 32'(m_busy), 32'd1);
    endtask

    // Offsets are relative to the accept cycle T; stops once tx_ready returns
    task automatic track(output int k_rx, output int k_cs, output int k_rdy);
        k_rx = -1; k_cs = -1; k_rdy = -1;
        for (int k = 2; k <= 300; k++) begin
            @(negedge clk);
            if (m_rxv && k_rx < 0) k_rx = k;
            if (m_cs && k_cs < 0) k_cs = k;
            if (m_ready && k_rdy < 0) k_rdy = k;
            if (k_rdy >= 0) break;
        end
    endtask

    task automatic drain();
        logic [8:0] e;
        while (rd_tx != n_tx_obs) begin
            e = (exp_tx.size() != 0) ? exp_tx.pop_front() : 9'h100;
            check("mosi_byte", 32'(obs_tx[rd_tx % 64]), 32'(e));
            rd_tx++;
        end
        while (rd_rx != n_rx_obs) begin
            e = (exp_rx.size() != 0) ? exp_rx.pop_front() : 9'h100;
            check("rx_byte", 32'(obs_rx[rd_rx % 64]), 32'(e));
            rd_rx++;
        end
    endtask

    initial begin
        int div, k_rx, k_cs, k_rdy, base_r, base_v, r, bad;
        logic psck;
        tx_data = 8'h00; tx_last = 1'b0; tx_valid = 1'b0; rst_n = 1'b0;
        sel = 2'd2; mode = 2'd0; pat = 16'h0000; pat_base = 0;

        repeat (3) @(negedge clk);
        check("rst_cs", 32'(m_cs), 32'd1);
        check("rst_sck", 32'(m_sck), 32'd0);
        check("rst_mosi", 32'(m_mosi), 32'd0);
        check("rst_ready", 32'(m_ready), 32'd0);
        check("rst_rxv", 32'(m_rxv), 32'd0);
        check("rst_rxd", 32'(m_rxd), 32'd0);
        check("rst_busy", 32'(m_busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(m_ready), 32'd1);

        // Single byte 0xA5, DIV=2, MISO low
        div = 2; base_r = rise_cnt; base_v = rxv_cnt;
        send(8'hA5, 1'b1, 8'h00, 1'b1, 1'b0);
        track(k_rx, k_cs, k_rdy);
        check("a5_rxv_time", 32'(k_rx), 32'(1 + 16 * div));
        check("a5_cs_low_cycles", 32'(k_cs - 1), 32'(17 * div));
        check("a5_ready_time", 32'(k_rdy), 32'(1 + 18 * div));
        @(negedge clk);
        drain();
        check("a5_rises", 32'(rise_cnt - base_r), 32'd8);
        check("a5_rxv_pulses", 32'(rxv_cnt - base_v), 32'd1);
        check("a5_rx_data", 32'(m_rxd), 32'h00);

        // Loopback 0x3C, DIV=3
        sel = 2'd3; mode = 2'd1; div = 3;
        @(negedge clk);
        send(8'h3C, 1'b1, 8'h3C, 1'b1, 1'b0);
        track(k_rx, k_cs, k_rdy);
        check("loop_rxv_time", 32'(k_rx), 32'(1 + 16 * div));
        check("loop_ready_time", 32'(k_rdy), 32'(1 + 18 * div));
        @(negedge clk);
        drain();
        check("loop_rx_data", 32'(m_rxd), 32'h3C);

        // Burst 0x12 then 0x34 with a stall in WAIT, DIV=2
        sel = 2'd2; mode = 2'd0; div = 2;
        @(negedge clk);
        base_r = rise_cnt; base_v = rxv_cnt;
        send(8'h12, 1'b0, 8'h00, 1'b1, 1'b0);
        track(k_rx, k_cs, k_rdy);
        check("burst1_rxv_time", 32'(k_rx), 32'(1 + 16 * div));
        check("burst1_wait_ready", 32'(k_rdy), 32'(1 + 16 * div));
        check("burst1_cs_stays_low", 32'(k_cs), 32'hFFFF_FFFF);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (m_cs !== 1'b0 || m_ready !== 1'b1 || m_sck !== 1'b0) bad++;
        end
        check("wait_state_bad_cycles", 32'(bad), 32'd0);
        send(8'h34, 1'b1, 8'h00, 1'b1, 1'b0);
        track(k_rx, k_cs, k_rdy);
        check("burst2_cs_rise", 32'(k_cs), 32'(1 + 16 * div + 2));
        check("burst2_ready_time", 32'(k_rdy), 32'(1 + 18 * div));
        @(negedge clk);
        drain();
        check("burst_rises", 32'(rise_cnt - base_r), 32'd16);
        check("burst_rxv_pulses", 32'(rxv_cnt - base_v), 32'd2);

        // tx_valid held high with 0xFF during a 0x00 transfer
        send(8'h00, 1'b1, 8'h00, 1'b1, 1'b1);
        tx_data = 8'hFF;
        track(k_rx, k_cs, k_rdy);
        check("held_next_accept_time", 32'(k_rdy), 32'(1 + 18 * div));
        send(8'hFF, 1'b1, 8'h00, 1'b1, 1'b0);
        track(k_rx, k_cs, k_rdy);
        @(negedge clk);
        drain();

        // Reset pulse after the third SCK rise, then a clean 0x81
        base_v = rxv_cnt;
        send(8'hC3, 1'b1, 8'h00, 1'b0, 1'b0);
        r = 0; psck = m_sck;
        for (int n = 0; n < 200 && r < 3; n++) begin
            @(negedge clk);
            if (m_sck && !psck) r++;
            psck = m_sck;
        end
        check("abort_rises_seen", 32'(r), 32'd3);
        rst_n = 1'b0;
        #1;
        check("abort_cs", 32'(m_cs), 32'd1);
        check("abort_sck", 32'(m_sck), 32'd0);
        check("abort_rxv", 32'(m_rxv), 32'd0);
        check("abort_busy", 32'(m_busy), 32'd0);
        check("abort_ready", 32'(m_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_ready_after_release", 32'(m_ready), 32'd1);
        base_r = rise_cnt;
        send(8'h81, 1'b1, 8'h00, 1'b1, 1'b0);
        track(k_rx, k_cs, k_rdy);
        check("post_abort_rxv_time", 32'(k_rx), 32'(1 + 16 * div));
        check("post_abort_cs_rise", 32'(k_cs), 32'(1 + 17 * div));
        @(negedge clk);
        drain();
        check("post_abort_rises", 32'(rise_cnt - base_r), 32'd8);
        check("post_abort_rxv_pulses", 32'(rxv_cnt - base_v), 32'd1);

        // DIV=1, 0x00 then 0xFF with MISO pattern 0x5A, 0xA5
        sel = 2'd1; mode = 2'd2; div = 1;
        pat = 16'h5AA5; pat_base = rise_cnt;
        @(negedge clk);
        send(8'h00, 1'b0, 8'h5A, 1'b1, 1'b0);
        track(k_rx, k_cs, k_rdy);
        check("div1_b1_rxv_time", 32'(k_rx), 32'(1 + 16 * div));
        check("div1_b1_rx_data", 32'(m_rxd), 32'h5A);
        send(8'hFF, 1'b1, 8'hA5, 1'b1, 1'b0);
        track(k_rx, k_cs, k_rdy);
        check("div1_b2_rxv_time", 32'(k_rx), 32'(1 + 16 * div));
        check("div1_b2_cs_rise", 32'(k_cs), 32'(1 + 17 * div));
        check("div1_b2_ready_time", 32'(k_rdy), 32'(1 + 18 * div));
        @(negedge clk);
        drain();
        check("div1_rx_data_hold", 32'(m_rxd), 32'hA5);

        check("exp_tx_left", 32'(exp_tx.size()), 32'd0);
        check("exp_rx_left", 32'(exp_rx.size()), 32'd0);
        check("rxv_multi_cycle", 32'(dbl_rxv), 32'd0);
        check("sck_with_cs_high", 32'(sck_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
